// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Bridges the L2 cache's 256-bit line port to a 64-bit burst memory bus.
//   A line read collects four ascending 64-bit beats into the line buffer.
//   A line write latches the line and then drives it out as four beats.
//   Only one line transfer is in flight at a time.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   line_i / line_o     write line in / assembled read line out (256 bits)
//   address_i           line address from L2
//   read_i / write_i    line requests, held by L2 until resp_o
//   resp_o              one-cycle line completion pulse
//   burst_i / burst_o   read beat in / write beat out (64 bits)
//   address_o           line-aligned burst address to memory
//   read_o / write_o    burst requests to memory
//   resp_i              memory beat strobe, one beat per high cycle
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for read_i / write_i (write wins when both high)
// READ    | read_o high, capture burst_i into buffer on each resp_i
// WRITE   | write_o high, present buffer beat k on burst_o
// DONE    | resp_o high for one cycle, then back to IDLE

module cacheline_adaptor (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    input  logic [31:0]  address_i,
    input  logic         read_i,
    input  logic         write_i,
    output logic         resp_o,
    input  logic [63:0]  burst_i,
    output logic [63:0]  burst_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    input  logic         resp_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     k_q, k_d;
    logic [255:0]   buf_q, buf_d;
    logic [31:0]    addr_q, addr_d;
    logic [7:0]     beat_base;

    // Bit offset of beat k inside the line; beat 0 occupies bits 63:0.
    assign beat_base = {k_q, 6'd0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            k_q     <= 2'd0;
            buf_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (write_i) begin
                    buf_d   = line_i;
                    addr_d  = address_i;
                    k_d     = 2'd0;
                    state_d = ST_WRITE;
                end else if (read_i) begin
                    addr_d  = address_i;
                    k_d     = 2'd0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (resp_i) begin
                    buf_d[beat_base +: 64] = burst_i;
                    k_d = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WRITE: begin
                if (resp_i) begin
                    k_d = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decode the state register only, so memory and L2
    // never see a combinational path from their own strobes.
    assign read_o    = (state_q == ST_READ);
    assign write_o   = (state_q == ST_WRITE);
    assign resp_o    = (state_q == ST_DONE);
    assign burst_o   = write_o ? buf_q[beat_base +: 64] : 64'd0;
    assign address_o = (read_o || write_o) ? {addr_q[31:5], 5'b0} : 32'd0;
    assign line_o    = buf_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;

    logic         clk;
    logic         reset_n;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int checks = 0;
    int errors = 0;

    // Reference view: the line the adaptor's buffer should currently hold.
    logic [255:0] model_line;

    cacheline_adaptor dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return a & 32'hFFFF_FFE0;
    endfunction

    // One complete line transfer. Entered and left at 1 time unit after a
    // rising edge with the DUT idle. pat bit i gives resp_i in burst cycle i
    // (1 once the pattern is exhausted) when use_pat is set, else random.
    task automatic run_line(input bit is_wr, input logic [31:0] addr,
                            input logic [255:0] data, input logic [15:0] pat,
                            input bit use_pat, input bit spur_done,
                            input bit keep_read);
        int beats;
        int cyc;
        logic r;
        if (is_wr) begin
            write_i = 1'b1;
            line_i  = data;
        end else begin
            read_i = 1'b1;
        end
        address_i = addr;
        @(posedge clk); #1;
        // Acceptance done; later changes on the L2 side must not matter.
        line_i    = rand_line();
        address_i = $urandom;
        beats = 0;
        cyc   = 0;
        while (beats < 4 && cyc < 40) begin
            if (use_pat) r = (cyc < 16) ? pat[cyc] : 1'b1;
            else         r = ($urandom_range(0, 2) != 0);
            resp_i  = r;
            burst_i = (!is_wr && r) ? data[64*beats +: 64] : {$urandom, $urandom};
            @(negedge clk);
            chk("burst_read_o",  {255'd0, read_o},  {255'd0, !is_wr});
            chk("burst_write_o", {255'd0, write_o}, {255'd0, is_wr});
            chk("burst_resp_o",  {255'd0, resp_o},  256'd0);
            chk("burst_addr_o",  {224'd0, address_o}, {224'd0, line_addr(addr)});
            if (is_wr) chk("burst_data_o", {192'd0, burst_o}, {192'd0, data[64*beats +: 64]});
            @(posedge clk); #1;
            if (r) beats++;
            cyc++;
        end
        model_line = data;
        resp_i  = spur_done;
        burst_i = {$urandom, $urandom};
        @(negedge clk);
        chk("done_resp_o",  {255'd0, resp_o},  256'd1);
        chk("done_read_o",  {255'd0, read_o},  256'd0);
        chk("done_write_o", {255'd0, write_o}, 256'd0);
        chk("done_addr_o",  {224'd0, address_o}, 256'd0);
        chk("done_line_o",  line_o, model_line);
        resp_i  = 1'b0;
        write_i = 1'b0;
        if (!keep_read) read_i = 1'b0;
        @(posedge clk); #1;
        chk("idle_resp_o", {255'd0, resp_o}, 256'd0);
        chk("idle_req_o",  {254'd0, read_o, write_o}, 256'd0);
        chk("idle_line_o", line_o, model_line);
    endtask

    initial begin
        logic [255:0] l1;
        logic [255:0] wl;
        logic [255:0] tmp;
        reset_n   = 1'b0;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        model_line = '0;
        #3;
        chk("rst_read_o",  {255'd0, read_o},  256'd0);
        chk("rst_write_o", {255'd0, write_o}, 256'd0);
        chk("rst_resp_o",  {255'd0, resp_o},  256'd0);
        chk("rst_addr_o",  {224'd0, address_o}, 256'd0);
        chk("rst_burst_o", {192'd0, burst_o}, 256'd0);
        chk("rst_line_o",  line_o, 256'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Contiguous read.
        l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        read_i = 1'b1;
        address_i = 32'h1234_5678;
        @(posedge clk); #1;
        chk("plan_addr_o", {224'd0, address_o}, {224'd0, 32'h1234_5660});
        // Hand the rest of this read to the generic sequence by rewinding:
        // finish it manually with four contiguous beats.
        for (int b = 0; b < 4; b++) begin
            resp_i  = 1'b1;
            burst_i = l1[64*b +: 64];
            @(negedge clk);
            chk("plan_read_o", {255'd0, read_o}, 256'd1);
            chk("plan_resp_o", {255'd0, resp_o}, 256'd0);
            @(posedge clk); #1;
        end
        resp_i = 1'b0;
        read_i = 1'b0;
        @(negedge clk);
        chk("plan_resp_cycle5", {255'd0, resp_o}, 256'd1);
        chk("plan_line_o", line_o, l1);
        model_line = l1;
        @(posedge clk); #1;
        chk("plan_resp_pulse", {255'd0, resp_o}, 256'd0);

        // Read with gapped beats 1,0,0,1,1,0,1.
        run_line(1'b0, 32'h1234_5678, l1, 16'h0059, 1'b1, 1'b0, 1'b0);

        // Write with beat n = n.
        wl = {64'd3, 64'd2, 64'd1, 64'd0};
        run_line(1'b1, 32'hABCD_0123, wl, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        // Spurious resp_i in IDLE.
        for (int i = 0; i < 3; i++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            @(negedge clk);
            chk("spur_idle_req", {253'd0, read_o, write_o, resp_o}, 256'd0);
            chk("spur_idle_line", line_o, model_line);
            @(posedge clk); #1;
        end
        resp_i = 1'b0;

        // Spurious resp_i in DONE (checked inside run_line).
        run_line(1'b0, 32'h0000_1FFF, rand_line(), 16'h0000, 1'b0, 1'b1, 1'b0);

        // Simultaneous read and write: write first, read after one idle cycle.
        read_i = 1'b1;
        run_line(1'b1, 32'h5555_AAAA, rand_line(), 16'h0000, 1'b0, 1'b0, 1'b1);
        run_line(1'b0, 32'h7777_0040, rand_line(), 16'h0000, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset after beat 2 of a read.
        tmp = rand_line();
        read_i = 1'b1;
        address_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        for (int b = 0; b < 2; b++) begin
            resp_i  = 1'b1;
            burst_i = tmp[64*b +: 64];
            @(posedge clk); #1;
        end
        resp_i = 1'b0;
        read_i = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_read_o", {255'd0, read_o}, 256'd0);
        chk("arst_resp_o", {255'd0, resp_o}, 256'd0);
        chk("arst_addr_o", {224'd0, address_o}, 256'd0);
        chk("arst_line_o", line_o, 256'd0);
        model_line = '0;
        @(posedge clk); #1;
        chk("arst_hold_resp", {255'd0, resp_o}, 256'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_line(1'b0, 32'hDEAD_BEEF, tmp, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        // Randomised mix of transfers.
        for (int t = 0; t < 8; t++) begin
            run_line(1'($urandom_range(0, 1)), $urandom, rand_line(),
                     16'h0000, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
